sigma_delta_decimator: RTL and testbench

SIGMA_DELTA_DECIMATOR -- requirements
Module: sigma_delta_decimator

---
 rtl/sigma_delta_decimator.sv | 77 +++++++
 tb/tb_sigma_delta_decimator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_decimator.sv
// Two-stage CIC (sinc^2) decimator for a sigma-delta code stream.
// Integrators run on en strobes; the comb pair runs once per frame, one edge after the frame closes.
module sigma_delta_decimator #(
    parameter  int IN_WIDTH  = 1,
    parameter  int LOG2_RATE = 2,
    localparam int EXT_WIDTH = (IN_WIDTH > 2) ? IN_WIDTH : 2,
    localparam int OUT_WIDTH = EXT_WIDTH + 2 * LOG2_RATE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [IN_WIDTH-1:0]         sdIn,
    output logic signed [OUT_WIDTH-1:0] dataOut,
    output logic                        dataValid
);

    logic signed [OUT_WIDTH-1:0] w_x;
    logic signed [OUT_WIDTH-1:0] w_c1;
    logic signed [OUT_WIDTH-1:0] w_c2;
    logic                        w_frame_end;

    logic signed [OUT_WIDTH-1:0] r_i1;
    logic signed [OUT_WIDTH-1:0] r_i2;
    logic signed [OUT_WIDTH-1:0] r_i2d;
    logic signed [OUT_WIDTH-1:0] r_c1d;
    logic [LOG2_RATE-1:0]        r_phase;
    logic                        r_pending;
    logic signed [OUT_WIDTH-1:0] r_data_out;
    logic                        r_data_valid;

    // A single-bit code is bipolar (+1/-1); wider codes are already two's complement.
    generate
        if (IN_WIDTH == 1) begin : g_bipolar
            assign w_x = sdIn[0] ? OUT_WIDTH'(1) : '1;
        end else begin : g_multibit
            assign w_x = OUT_WIDTH'(signed'(sdIn));
        end
    endgenerate

    assign w_frame_end = en && (&r_phase);

    // Wrap-around in the integrators is harmless: the comb differences
    // recover the exact result modulo 2^OUT_WIDTH, which is wide enough.
    assign w_c1 = r_i2 - r_i2d;
    assign w_c2 = w_c1 - r_c1d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i1         <= '0;
            r_i2         <= '0;
            r_i2d        <= '0;
            r_c1d        <= '0;
            r_phase      <= '0;
            r_pending    <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (en) begin
                r_i1    <= r_i1 + w_x;
                r_i2    <= r_i2 + r_i1;
                r_phase <= r_phase + LOG2_RATE'(1);
            end
            // With R >= 2 a new frame can never close on the servicing edge.
            r_pending <= w_frame_end;
            if (r_pending) begin
                r_i2d      <= r_i2;
                r_c1d      <= w_c1;
                r_data_out <= w_c2;
            end
            r_data_valid <= r_pending;
        end
    end

    assign dataOut   = r_data_out;
    assign dataValid = r_data_valid;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator: table-driven frames, reset corner cases, random strobes
// against a convolution model, and a long multi-bit run on a second configuration.
module tb_sigma_delta_decimator;

    localparam int R   = 4;
    localparam int OW  = 6;
    localparam int OWW = 8;

    typedef struct {
        logic sd_a;
        logic sd_b;
        int   en_period;
        int   frames;
        int   exp_first;
        int   exp_steady;
    } vec_t;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic [0:0]            sdIn;
    logic signed [OW-1:0]  dataOut;
    logic                  dataValid;

    logic                  rst_w;
    logic                  en_w;
    logic [1:0]            sd_w;
    logic signed [OWW-1:0] dataOut_w;
    logic                  dataValid_w;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    logic [OW-1:0] exp_q[$];
    int            cyc_q[$];
    int            hist[$];
    bit            tbl_mode;
    int            tbl_first;
    int            tbl_steady;
    vec_t          vecs[6];

    sigma_delta_decimator #(.IN_WIDTH(1), .LOG2_RATE(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sdIn(sdIn),
        .dataOut(dataOut), .dataValid(dataValid)
    );

    sigma_delta_decimator #(.IN_WIDTH(2), .LOG2_RATE(3)) dut_w (
        .clk(clk), .rst(rst_w), .en(en_w), .sdIn(sd_w),
        .dataOut(dataOut_w), .dataValid(dataValid_w)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ramp(input int d);
        return (d > 0) ? d : 0;
    endfunction

    // sinc^2 output after n strobes as a direct convolution with the triangular kernel.
    function automatic int model_y();
        int n;
        int y;
        n = hist.size();
        y = 0;
        for (int m = 1; m <= n; m++) begin
            y += hist[m-1] * (ramp(n - m) - 2 * ramp(n - R - m) + ramp(n - 2 * R - m));
        end
        return y;
    endfunction

    // Driver: one cycle of stimulus, and scoreboard bookkeeping for it.
    task automatic step(input logic r, input logic e, input logic s);
        int ev;
        @(negedge clk);
        rst  = r;
        en   = e;
        sdIn = s;
        if (r) begin
            hist.delete();
            exp_q.delete();
            cyc_q.delete();
        end else if (e) begin
            hist.push_back(s ? 1 : -1);
            if (hist.size() % R == 0) begin
                if (tbl_mode) ev = (hist.size() == R) ? tbl_first : tbl_steady;
                else          ev = model_y();
                exp_q.push_back(OW'(ev));
                cyc_q.push_back(cyc + 2);
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("reset_dataout", int'(dataOut), 0);
        check("reset_datavalid", int'(dataValid), 0);
    endtask

    task automatic drain();
        for (int t = 0; t < 8 && exp_q.size() > 0; t++) step(1'b0, 1'b0, 1'b0);
        if (exp_q.size() > 0) begin
            check("drain_missing", 0, exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        tbl_mode   = 1'b1;
        tbl_first  = v.exp_first;
        tbl_steady = v.exp_steady;
        do_reset();
        for (int k = 0; k < v.frames * R; k++) begin
            for (int j = 1; j < v.en_period; j++) step(1'b0, 1'b0, logic'($urandom_range(0, 1)));
            step(1'b0, 1'b1, (k % 2 == 0) ? v.sd_a : v.sd_b);
        end
        drain();
    endtask

    // Monitor: compare each dataValid pulse against the scoreboard, value and cycle.
    initial begin
        logic [OW-1:0] e;
        int            c;
        forever begin
            @(posedge clk);
            #1;
            if (dataValid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("dataout", int'(dataOut), int'($signed(e)));
                    check("valid_cycle", cyc, c);
                end
            end else if (cyc_q.size() > 0 && cyc_q[0] < cyc) begin
                check("missing_valid", 0, 1);
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
            end
        end
    end

    initial begin
        int outs;
        int t;
        rst   = 1'b1;
        en    = 1'b0;
        sdIn  = 1'b0;
        rst_w = 1'b1;
        en_w  = 1'b0;
        sd_w  = 2'b00;

        vecs[0] = '{1'b1, 1'b1, 1, 4,  6,  16};
        vecs[1] = '{1'b0, 1'b0, 1, 4, -6, -16};
        vecs[2] = '{1'b1, 1'b0, 1, 4,  2,   0};
        vecs[3] = '{1'b1, 1'b1, 3, 3,  6,  16};
        vecs[4] = '{1'b0, 1'b0, 2, 3, -6, -16};
        vecs[5] = '{1'b0, 1'b1, 1, 3, -2,   0};

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset two strobes into a frame: the partial frame is dropped.
        tbl_mode   = 1'b1;
        tbl_first  = 6;
        tbl_steady = 16;
        do_reset();
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b1);
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1);
        drain();

        // Reset right after the frame closes: the pending output is dropped.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
        drain();

        // Random strobes and data with a mid-run reset, checked against the model.
        tbl_mode = 1'b0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            if (c == 150) do_reset();
            else step(1'b0, logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)));
        end
        drain();
        step(1'b0, 1'b0, 1'b0);

        // Multi-bit, R=8, constant -2: first -56, then -128 every 8 cycles.
        @(negedge clk);
        rst_w = 1'b1;
        en_w  = 1'b1;
        sd_w  = 2'b10;
        @(posedge clk);
        #1;
        check("wide_reset_dataout", int'(dataOut_w), 0);
        check("wide_reset_datavalid", int'(dataValid_w), 0);
        @(negedge clk);
        rst_w = 1'b0;
        outs  = 0;
        t     = 0;
        while (outs < 1000 && t < 8100) begin
            @(posedge clk);
            #1;
            t++;
            if (dataValid_w) begin
                check("wide_dataout", int'(dataOut_w), (outs == 0) ? -56 : -128);
                check("wide_valid_cycle", t, 9 + 8 * outs);
                outs++;
            end
        end
        if (outs < 1000) check("wide_output_count", outs, 1000);
        @(negedge clk);
        en_w = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
